// File: rtl/diff_freq_serial_out_ch_pkg.sv
// Shared defaults, mode encoding and FSM state type for the per-channel serializer.
package diff_freq_serial_out_ch_pkg;

    localparam int unsigned DEF_DATA_BIT   = 32;
    localparam int unsigned DEF_PERIOD_W   = 8;
    localparam logic        DEF_IDLE_LEVEL = 1'b0;

    // Matches the decoder's control-byte encoding
    localparam logic MODE_ONE_SHOT = 1'b0;
    localparam logic MODE_REPEAT   = 1'b1;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

endpackage

// File: rtl/diff_freq_serial_out_ch_bit_period_counter.sv
// Loadable down-counter timing one serial bit; a zero period is treated as one cycle.
module bit_period_counter #(
    parameter int unsigned PERIOD_W = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                load_i,
    input  logic [PERIOD_W-1:0] period_i,
    output logic                last_cycle_o
);

    logic [PERIOD_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = (period_i == '0) ? '0 : period_i - PERIOD_W'(1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - PERIOD_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_cycle_o = (cnt_q == '0);

endmodule

// File: rtl/diff_freq_serial_out_ch.sv
// Per-channel serializer: sends a double-buffered pattern LSB first, each bit held for
// a slow or fast period selected by the matching frequency-pattern bit.
module diff_freq_serial_out_ch
    import diff_freq_serial_out_ch_pkg::*;
#(
    parameter int unsigned DATA_BIT   = DEF_DATA_BIT,
    parameter int unsigned PERIOD_W   = DEF_PERIOD_W,
    parameter logic        IDLE_LEVEL = DEF_IDLE_LEVEL,
    localparam int unsigned IDX_W     = $clog2(DATA_BIT)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                load_i,
    input  logic [DATA_BIT-1:0] output_pattern_i,
    input  logic [DATA_BIT-1:0] freq_pattern_i,
    input  logic [PERIOD_W-1:0] slow_period_i,
    input  logic [PERIOD_W-1:0] fast_period_i,
    input  logic                mode_i,
    input  logic                start_i,
    input  logic                stop_i,
    output logic                serial_o,
    output logic                busy_o,
    output logic [IDX_W-1:0]    bit_idx_o,
    output logic                done_tick_o
);

    state_e state_q, state_d;

    logic [DATA_BIT-1:0] sh_pat_q, sh_freq_q, act_pat_q, act_freq_q;
    logic [PERIOD_W-1:0] sh_slow_q, sh_fast_q, act_slow_q, act_fast_q;
    logic                sh_mode_q, act_mode_q;

    logic                serial_q, serial_d;
    logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
    logic                done_q, done_d;

    logic                copy;
    logic                cnt_load;
    logic [PERIOD_W-1:0] cnt_period;
    logic                last_cycle;

    // A load coinciding with a copy bypasses the shadow so the new values take effect at once
    logic [DATA_BIT-1:0] src_pat, src_freq;
    logic [PERIOD_W-1:0] src_slow, src_fast;
    logic                src_mode;

    assign src_pat  = load_i ? output_pattern_i : sh_pat_q;
    assign src_freq = load_i ? freq_pattern_i   : sh_freq_q;
    assign src_slow = load_i ? slow_period_i    : sh_slow_q;
    assign src_fast = load_i ? fast_period_i    : sh_fast_q;
    assign src_mode = load_i ? mode_i           : sh_mode_q;

    logic             start_ok;
    logic             last_bit;
    logic [IDX_W-1:0] idx_inc;

    assign start_ok = start_i & ~stop_i;
    assign last_bit = (bit_idx_q == IDX_W'(DATA_BIT - 1));
    assign idx_inc  = bit_idx_q + IDX_W'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (start_ok) state_d = StRun;
            StRun: begin
                if (stop_i || (last_cycle && last_bit && act_mode_q == MODE_ONE_SHOT)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        copy       = 1'b0;
        cnt_load   = 1'b0;
        cnt_period = '0;
        serial_d   = serial_q;
        bit_idx_d  = bit_idx_q;
        done_d     = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_ok) begin
                    copy       = 1'b1;
                    cnt_load   = 1'b1;
                    cnt_period = src_freq[0] ? src_fast : src_slow;
                    serial_d   = src_pat[0];
                    bit_idx_d  = '0;
                end
            end
            StRun: begin
                if (stop_i) begin
                    serial_d  = IDLE_LEVEL;
                    bit_idx_d = '0;
                end else if (last_cycle && last_bit) begin
                    done_d    = 1'b1;
                    bit_idx_d = '0;
                    if (act_mode_q == MODE_REPEAT) begin
                        copy       = 1'b1;
                        cnt_load   = 1'b1;
                        cnt_period = src_freq[0] ? src_fast : src_slow;
                        serial_d   = src_pat[0];
                    end else begin
                        serial_d = IDLE_LEVEL;
                    end
                end else if (last_cycle) begin
                    cnt_load   = 1'b1;
                    cnt_period = act_freq_q[idx_inc] ? act_fast_q : act_slow_q;
                    serial_d   = act_pat_q[idx_inc];
                    bit_idx_d  = idx_inc;
                end
            end
            default: begin
                serial_d  = IDLE_LEVEL;
                bit_idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sh_pat_q   <= '0;
            sh_freq_q  <= '0;
            sh_slow_q  <= '0;
            sh_fast_q  <= '0;
            sh_mode_q  <= MODE_ONE_SHOT;
            act_pat_q  <= '0;
            act_freq_q <= '0;
            act_slow_q <= '0;
            act_fast_q <= '0;
            act_mode_q <= MODE_ONE_SHOT;
            serial_q   <= IDLE_LEVEL;
            bit_idx_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            if (load_i) begin
                sh_pat_q  <= output_pattern_i;
                sh_freq_q <= freq_pattern_i;
                sh_slow_q <= slow_period_i;
                sh_fast_q <= fast_period_i;
                sh_mode_q <= mode_i;
            end
            if (copy) begin
                act_pat_q  <= src_pat;
                act_freq_q <= src_freq;
                act_slow_q <= src_slow;
                act_fast_q <= src_fast;
                act_mode_q <= src_mode;
            end
            serial_q  <= serial_d;
            bit_idx_q <= bit_idx_d;
            done_q    <= done_d;
        end
    end

    bit_period_counter #(
        .PERIOD_W (PERIOD_W)
    ) u_bit_period_counter (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .load_i       (cnt_load),
        .period_i     (cnt_period),
        .last_cycle_o (last_cycle)
    );

    assign serial_o    = serial_q;
    assign busy_o      = (state_q == StRun);
    assign bit_idx_o   = bit_idx_q;
    assign done_tick_o = done_q;

endmodule
